uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte buffer between the processor output path and the uart transmitter.
//   Accepts bytes from the core in single-cycle writes and paces them into the
//   uart's data_tx/start_transmit inputs, one frame at a time. The uart has no
//   busy output, so this block times each frame itself and holds data_tx stable.
// PARAMETERS
//   DEPTH         16   FIFO entries; power of 2, >= 2
//   FRAME_CYCLES  11   clk cycles from the start_transmit pulse to the next allowed pulse (>= 11)
// PORTS
//   clk             in   1   system clock, all logic on posedge
//   reset           in   1   asynchronous, active-high; clears all state
//   wr_data         in   8   byte to enqueue
//   wr_en           in   1   enqueue wr_data this cycle
//   full            out  1   count == DEPTH
//   empty           out  1   count == 0
//   count           out  $clog2(DEPTH)+1  number of stored bytes
//   overflow        out  1   1-cycle pulse: wr_en while full, byte dropped
//   data_tx         out  8   byte under transmission, to uart data_tx
//   start_transmit  out  1   1-cycle pulse, to uart start_transmit
//   busy            out  1   high in START or WAIT
// BEHAVIOUR
//   Reset (async, any time, incl. mid-frame): ptrs=0, count=0, full=0, empty=1,
//     overflow=0, data_tx=8'h00, start_transmit=0, busy=0, state=IDLE, timer=0.
//     A partially sent frame is abandoned; the uart is reset separately.
//   Storage: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH; count tracked separately.
//   Write: wr_en && !full -> mem[wr_ptr]<=wr_data, wr_ptr++. wr_en && full ->
//     no store, overflow=1 next cycle only. All outputs registered.
//   FSM states:
//     IDLE : if !empty -> data_tx<=mem[rd_ptr], rd_ptr++, state<=START.
//     START: start_transmit=1 (this cycle only); timer<=FRAME_CYCLES-2; state<=WAIT.
//     WAIT : timer--; at timer==0 -> state<=IDLE. data_tx held unchanged.
//   Pacing: consecutive start_transmit pulses exactly FRAME_CYCLES+1 clk apart
//     when the FIFO stays non-empty (IDLE costs one cycle to pop).
//   Latency: write at edge N into empty idle FIFO -> pop at edge N+1,
//     start_transmit high in cycle after edge N+2... i.e. visible after edge N+2.
//   Simultaneous write and pop (IDLE pop same edge): count unchanged; write
//     accepted even if full is 1 that cycle only when a pop occurs (full is
//     combinational on count: write while full with concurrent pop IS accepted).
//   Read of an entry written the same cycle is not possible (empty check uses
//     pre-edge count); the byte is popped next IDLE cycle.
//   data_tx is only updated on pop; between frames it holds the last byte.
//   count width DEPTH+1 values: 0..DEPTH; never wraps; no underflow possible.
// TESTING
//   Reset, then write 8'h41 once -> start_transmit pulses 2 cycles later,
//     data_tx=8'h41 held for 11 cycles, empty=1, busy drops after WAIT.
//   Burst-write 8'h30..8'h33 in 4 consecutive cycles -> 4 pulses spaced 12
//     cycles, data_tx sequence 30,31,32,33; with uart attached, tx line shows
//     four correct 10-bit frames back to back.
//   Write 17 bytes with DEPTH=16 while FSM stalled by prior frame -> full=1
//     after 16 stores (minus pops), 17th write -> overflow pulse, byte absent from output.
//   Fill to full, write during the IDLE pop cycle -> write accepted, count stays 16, no overflow.
//   Wrap-around: stream 40 bytes (0x00..0x27) at pacing rate -> all 40 emitted in order.
//   Assert reset mid-WAIT (timer=5) -> all outputs to reset values immediately
//     (async), FIFO empty, no start_transmit after release until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte buffer between the processor output path and the uart transmitter.
//   The core pushes bytes with single-cycle writes. The block pops them one at
//   a time into data_tx and pulses start_transmit once per frame. The uart has
//   no busy output, so the frame time is measured here with a down-counter.
//   data_tx is held stable from each pop until the next pop.
//
//   Pacing: while the FIFO stays non-empty, start_transmit pulses are
//   FRAME_CYCLES+1 clocks apart. This is one START cycle, FRAME_CYCLES-1 WAIT
//   cycles and one IDLE cycle that performs the pop.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           asynchronous, active-high; clears all state
//   wr_data[7:0]    byte to enqueue
//   wr_en           enqueue wr_data this cycle
//   full            stored byte count equals DEPTH
//   empty           stored byte count is zero
//   count           number of stored bytes, 0..DEPTH
//   overflow        1-cycle pulse: a write arrived while full and was dropped
//   data_tx[7:0]    byte under transmission, to the uart
//   start_transmit  1-cycle pulse, to the uart
//   busy            a frame is being started or timed (START or WAIT)
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               data_tx,
  output logic                     start_transmit,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(FRAME_CYCLES);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  // WAIT lasts FRAME_CYCLES-1 cycles (timer counts down to zero inclusive),
  // so START plus WAIT spans exactly one frame.
  localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(FRAME_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;
  logic [7:0]       data_tx_r;

  // Frame sequencer
  state_t           state_r;
  state_t           state_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_s;
  logic             start_r;
  logic             start_s;
  logic             busy_r;
  logic             busy_s;

  // Handshake terms
  logic             pop_s;
  logic             wr_accept_s;

  assign full           = full_r;
  assign empty          = empty_r;
  assign count          = count_r;
  assign overflow       = overflow_r;
  assign data_tx        = data_tx_r;
  assign start_transmit = start_r;
  assign busy           = busy_r;

  // Pop/accept decisions and next occupancy; a pop frees a slot in the same
  // edge, so a write against a full FIFO is still taken when a pop coincides.
  always_comb begin
    pop_s       = 1'b0;
    wr_accept_s = 1'b0;
    count_s     = count_r;
    if ((state_r == ST_IDLE) && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (wr_en && (!full_r || pop_s)) begin
      wr_accept_s = 1'b1;
    end else begin
      wr_accept_s = 1'b0;
    end
    case ({wr_accept_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FIFO storage, pointers, flags and the byte presented to the uart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      data_tx_r  <= 8'h00;
    end else begin
      if (wr_accept_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        // Non-blocking read sees the old entry even if the same slot is
        // written this edge (full FIFO with concurrent write and pop).
        data_tx_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_s;
      full_r     <= (count_s == DEPTH_C);
      empty_r    <= (count_s == CNT_ZERO);
      overflow_r <= wr_en && full_r && !pop_s;
    end
  end

  // Sequencer next state, frame timer and registered strobes
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    start_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        start_s = 1'b1;
        timer_s = TIMER_LOAD;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_r == TMR_ZERO) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = TMR_ZERO;
      end
    endcase
    if (state_s != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Sequencer state register; an async reset abandons any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      start_r <= start_s;
      busy_r  <= busy_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=16, FRAME_CYCLES=11).
// Inputs change 1 time unit after the rising edge. Outputs are read at the
// same point. A negedge monitor logs every start_transmit pulse: it records
// the byte on data_tx and the index of the rising edge that produced it.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] data_tx;
  logic       start_transmit;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int w0;
  logic [7:0] pulse_data[$];
  int         pulse_cyc[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(16), .FRAME_CYCLES(11)) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .data_tx(data_tx),
    .start_transmit(start_transmit),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_transmit) begin
      pulse_data.push_back(data_tx);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pulse_data.delete();
    pulse_cyc.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int b;
    b = budget;
    while ((pulse_data.size() < n) && (b > 0)) begin
      step();
      b--;
    end
    check("pulse_count", pulse_data.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while (busy && (b > 0)) begin
      step();
      b--;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 5'd0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_data"}, data_tx, 8'h00);
    check({tag, "_start"}, start_transmit, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();
    check_reset_state("post_rst");

    // Single byte: pop one edge after the write, pulse one edge later,
    // then the byte is held for the whole frame.
    clear_log();
    wr_en = 1'b1; wr_data = 8'h41;
    step(); w0 = cyc;
    wr_en = 1'b0;
    check("s_count1", count, 5'd1);
    check("s_empty0", empty, 1'b0);
    check("s_start_early", start_transmit, 1'b0);
    step();
    check("s_pop_data", data_tx, 8'h41);
    check("s_pop_busy", busy, 1'b1);
    check("s_pop_empty", empty, 1'b1);
    check("s_pop_start", start_transmit, 1'b0);
    step();
    check("s_pulse", start_transmit, 1'b1);
    check("s_pulse_data", data_tx, 8'h41);
    step();
    check("s_pulse_end", start_transmit, 1'b0);
    repeat (8) step();
    check("s_busy_late", busy, 1'b1);
    check("s_hold", data_tx, 8'h41);
    step();
    check("s_busy_drop", busy, 1'b0);
    check("s_hold_after", data_tx, 8'h41);
    check("s_npulses", pulse_data.size(), 1);
    check("s_latency", pulse_cyc[0], w0 + 2);

    // Burst of four: pulses every 12 cycles, in write order.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      step();
      if (i == 0) w0 = cyc;
    end
    wr_en = 1'b0;
    wait_pulses(4, 80);
    check("b_first", pulse_cyc[0], w0 + 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_data%0d", i), pulse_data[i], 8'h30 + 8'(i));
      if (i > 0) check($sformatf("b_gap%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 12);
    end
    wait_idle(30);

    // Overflow: one frame in flight, then 18 back-to-back writes.
    // One pop lands in the middle, so the 18th write meets a full FIFO.
    clear_log();
    exp_q.delete();
    wr_en = 1'b1; wr_data = 8'hA0;
    step();
    wr_en = 1'b0;
    exp_q.push_back(8'hA0);
    step();
    step();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      step();
      if (i < 17) exp_q.push_back(8'h80 + 8'(i));
      if (i == 15) begin
        check("o_count15", count, 5'd15);
        check("o_notfull", full, 1'b0);
      end
      if (i == 16) begin
        check("o_full", full, 1'b1);
        check("o_count16", count, 5'd16);
        check("o_noovf", overflow, 1'b0);
      end
      if (i == 17) begin
        check("o_ovf", overflow, 1'b1);
        check("o_count_hold", count, 5'd16);
      end
    end
    wr_en = 1'b0;
    step();
    check("o_ovf_pulse", overflow, 1'b0);

    // Full FIFO, write in the IDLE pop cycle: accepted, count stays 16.
    wait_idle(30);
    check("f_full_pre", full, 1'b1);
    wr_en = 1'b1; wr_data = 8'hE5;
    step();
    wr_en = 1'b0;
    exp_q.push_back(8'hE5);
    check("f_count", count, 5'd16);
    check("f_noovf", overflow, 1'b0);
    check("f_full", full, 1'b1);
    wait_pulses(19, 400);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("f_seq%0d", i), pulse_data[i], exp_q[i]);
    end
    wait_idle(30);
    check("f_drained_empty", empty, 1'b1);
    check("f_drained_count", count, 5'd0);

    // Wrap-around: 40 bytes at the pacing rate.
    clear_log();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      wr_en = 1'b0;
      repeat (11) step();
    end
    wait_pulses(40, 50);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("w_seq%0d", i), pulse_data[i], 8'(i));
    end
    wait_idle(30);

    // Reset while WAIT has timer 5: outputs clear before the next edge.
    wr_en = 1'b1; wr_data = 8'hD0; step();
    wr_data = 8'hD1; step();
    wr_data = 8'hD2; step();
    wr_en = 1'b0;
    repeat (4) step();
    check("r_pre_count", count, 5'd2);
    check("r_pre_busy", busy, 1'b1);
    check("r_pre_data", data_tx, 8'hD0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("r_async");
    clear_log();
    step();
    step();
    reset = 1'b0;
    repeat (30) step();
    check("r_no_pulse", pulse_data.size(), 0);
    check("r_empty", empty, 1'b1);
    check("r_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
